// File: rtl/trigger_wheel_sim_pkg.sv
// Shared defaults and helpers for the crank/cam trigger-wheel generator.
package trigger_wheel_sim_pkg;

    localparam int unsigned TRIG_TEETH          = 36;
    localparam int unsigned TRIG_MISSING        = 1;
    localparam int unsigned TRIG_PERIOD_W       = 16;
    localparam int unsigned TRIG_DEFAULT_PERIOD = 1000;
    localparam int unsigned TRIG_MIN_PERIOD     = 4;
    localparam int unsigned TRIG_CAM_SLOT       = 5;
    localparam int unsigned TRIG_CAM_WIDTH      = 2;
    localparam int unsigned TRIG_RAMP_STEP      = 10;

    // One slew step from cur toward tgt; lands exactly on tgt once within one step.
    function automatic logic [31:0] ramp_toward(input logic [31:0] cur,
                                                input logic [31:0] tgt,
                                                input logic [31:0] step);
        logic [31:0] res;
        res = cur;
        if (cur < tgt) begin
            res = ((tgt - cur) <= step) ? tgt : cur + step;
        end else if (cur > tgt) begin
            res = ((cur - tgt) <= step) ? tgt : cur - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/trigger_wheel_sim_tooth_timer.sv
// Tooth tick counter: produces the tooth-boundary strobe and owns the applied/target period.
module trigger_wheel_sim_tooth_timer
    import trigger_wheel_sim_pkg::*;
#(
    parameter int unsigned PERIOD_W       = TRIG_PERIOD_W,
    parameter int unsigned DEFAULT_PERIOD = TRIG_DEFAULT_PERIOD,
    parameter int unsigned MIN_PERIOD     = TRIG_MIN_PERIOD,
    parameter int unsigned RAMP_STEP      = TRIG_RAMP_STEP
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_ramp_mode,
    input  logic [PERIOD_W-1:0] i_period_in,
    input  logic                i_period_load,
    output logic                o_boundary,
    output logic [PERIOD_W-1:0] o_tick,
    output logic [PERIOD_W-1:0] o_cur_period
);

    localparam logic [PERIOD_W-1:0] DefPeriod = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [PERIOD_W-1:0] MinPeriod = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] One       = PERIOD_W'(1);

    logic [PERIOD_W-1:0] r_tick;
    logic [PERIOD_W-1:0] r_cur_period;
    logic [PERIOD_W-1:0] r_target;
    logic [PERIOD_W-1:0] w_load_val;
    logic [PERIOD_W-1:0] w_target;
    logic [PERIOD_W-1:0] w_next_period;
    logic                w_boundary;

    always_comb begin
        w_load_val = (i_period_in < MinPeriod) ? MinPeriod : i_period_in;
        // A load landing on the boundary cycle takes effect at that same boundary.
        w_target   = i_period_load ? w_load_val : r_target;
        w_boundary = i_enable && (r_tick == (r_cur_period - One));
        if (i_ramp_mode) begin
            w_next_period = PERIOD_W'(ramp_toward(32'(r_cur_period), 32'(w_target),
                                                  32'(RAMP_STEP)));
        end else begin
            w_next_period = w_target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick       <= '0;
            r_cur_period <= DefPeriod;
            r_target     <= DefPeriod;
        end else begin
            if (i_period_load) begin
                r_target <= w_load_val;
            end
            if (w_boundary) begin
                r_tick       <= '0;
                r_cur_period <= w_next_period;
            end else if (i_enable) begin
                r_tick <= r_tick + One;
            end
        end
    end

    assign o_boundary   = w_boundary;
    assign o_tick       = r_tick;
    assign o_cur_period = r_cur_period;

endmodule

// File: rtl/trigger_wheel_sim.sv
// N-M crank wheel, cam and gap-sync generator for driving the vrin path without a real sensor.
module trigger_wheel_sim
    import trigger_wheel_sim_pkg::*;
#(
    parameter int unsigned TEETH          = TRIG_TEETH,
    parameter int unsigned MISSING        = TRIG_MISSING,
    parameter int unsigned PERIOD_W       = TRIG_PERIOD_W,
    parameter int unsigned DEFAULT_PERIOD = TRIG_DEFAULT_PERIOD,
    parameter int unsigned MIN_PERIOD     = TRIG_MIN_PERIOD,
    parameter int unsigned CAM_SLOT       = TRIG_CAM_SLOT,
    parameter int unsigned CAM_WIDTH      = TRIG_CAM_WIDTH,
    parameter int unsigned RAMP_STEP      = TRIG_RAMP_STEP
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    input  logic                       i_ramp_mode,
    input  logic [PERIOD_W-1:0]        i_period_in,
    input  logic                       i_period_load,
    output logic                       o_crank,
    output logic                       o_cam,
    output logic                       o_sync_pulse,
    output logic [$clog2(TEETH)-1:0]   o_tooth_idx,
    output logic                       o_rev_odd,
    output logic [PERIOD_W-1:0]        o_cur_period
);

    localparam int unsigned IDX_W = $clog2(TEETH);
    localparam logic [IDX_W-1:0] LastSlot  = IDX_W'(TEETH - 1);
    localparam logic [IDX_W-1:0] FirstGap  = IDX_W'(TEETH - MISSING);
    localparam logic [IDX_W-1:0] CamLo     = IDX_W'(CAM_SLOT);
    localparam logic [IDX_W:0]   CamHi     = (IDX_W + 1)'(CAM_SLOT + CAM_WIDTH);

    if (TEETH < 4) begin : g_bad_teeth
        $error("TEETH must be at least 4");
    end
    if (MISSING < 1 || MISSING >= TEETH - 1) begin : g_bad_missing
        $error("MISSING must be in 1..TEETH-2");
    end
    if (CAM_SLOT + CAM_WIDTH > TEETH) begin : g_bad_cam
        $error("cam window must not wrap past the last slot");
    end
    if (DEFAULT_PERIOD < MIN_PERIOD) begin : g_bad_default
        $error("DEFAULT_PERIOD below MIN_PERIOD");
    end

    logic                w_boundary;
    logic [PERIOD_W-1:0] w_tick;
    logic [PERIOD_W-1:0] w_cur_period;
    logic                w_wrap_rev;
    logic [IDX_W-1:0]    w_next_idx;
    logic                w_crank;
    logic                w_cam;
    logic [IDX_W-1:0]    r_tooth_idx;
    logic                r_rev_odd;
    logic                r_crank;
    logic                r_cam;
    logic                r_sync;

    trigger_wheel_sim_tooth_timer #(
        .PERIOD_W       (PERIOD_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .MIN_PERIOD     (MIN_PERIOD),
        .RAMP_STEP      (RAMP_STEP)
    ) u_timer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_ramp_mode   (i_ramp_mode),
        .i_period_in   (i_period_in),
        .i_period_load (i_period_load),
        .o_boundary    (w_boundary),
        .o_tick        (w_tick),
        .o_cur_period  (w_cur_period)
    );

    always_comb begin
        w_wrap_rev = w_boundary && (r_tooth_idx == LastSlot);
        w_next_idx = w_wrap_rev ? '0 : r_tooth_idx + IDX_W'(1);
        w_crank    = i_enable && (w_tick < (w_cur_period >> 1)) && (r_tooth_idx < FirstGap);
        w_cam      = i_enable && r_rev_odd && (r_tooth_idx >= CamLo)
                     && ({1'b0, r_tooth_idx} < CamHi);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tooth_idx <= '0;
            r_rev_odd   <= 1'b0;
            r_crank     <= 1'b0;
            r_cam       <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_crank <= w_crank;
            r_cam   <= w_cam;
            // Sync and parity flip coincide with the first tick of slot 0.
            r_sync  <= w_wrap_rev;
            if (w_boundary) begin
                r_tooth_idx <= w_next_idx;
            end
            if (w_wrap_rev) begin
                r_rev_odd <= ~r_rev_odd;
            end
        end
    end

    assign o_crank      = r_crank;
    assign o_cam        = r_cam;
    assign o_sync_pulse = r_sync;
    assign o_tooth_idx  = r_tooth_idx;
    assign o_rev_odd    = r_rev_odd;
    assign o_cur_period = w_cur_period;

endmodule

// File: tb/tb_trigger_wheel_sim.sv
// Directed bench for trigger_wheel_sim with a crank/cam event scoreboard.
module tb_trigger_wheel_sim;

    localparam int TEETH    = 36;
    localparam int PERIOD_W = 16;
    localparam int IDX_W    = $clog2(TEETH);

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                ramp_mode;
    logic [PERIOD_W-1:0] period_in;
    logic                period_load;
    logic                crank;
    logic                cam;
    logic                sync_pulse;
    logic [IDX_W-1:0]    tooth_idx;
    logic                rev_odd;
    logic [PERIOD_W-1:0] cur_period;

    always #5 clk = ~clk;

    trigger_wheel_sim #(
        .TEETH          (36),
        .MISSING        (1),
        .PERIOD_W       (16),
        .DEFAULT_PERIOD (1000),
        .MIN_PERIOD     (4),
        .CAM_SLOT       (5),
        .CAM_WIDTH      (2),
        .RAMP_STEP      (10)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .i_ramp_mode   (ramp_mode),
        .i_period_in   (period_in),
        .i_period_load (period_load),
        .o_crank       (crank),
        .o_cam         (cam),
        .o_sync_pulse  (sync_pulse),
        .o_tooth_idx   (tooth_idx),
        .o_rev_odd     (rev_odd),
        .o_cur_period  (cur_period)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: rise-to-rise intervals, crank high widths, cam high widths.
    int exp_iv[$];
    int exp_hi[$];
    int exp_cam[$];
    bit mon_on     = 1'b0;
    bit cam_chk    = 1'b1;
    bit have_rise  = 1'b0;
    bit prev_crank = 1'b0;
    bit prev_cam   = 1'b0;
    int last_rise  = 0;
    int cam_rise   = 0;
    int n_rise     = 0;

    always @(negedge clk) begin
        if (crank && !prev_crank) begin
            if (mon_on && have_rise) begin
                if (exp_iv.size() == 0) check("crank_rise_unexpected", 0, 1);
                else check("crank_interval", cyc - last_rise, exp_iv.pop_front());
            end
            last_rise = cyc;
            have_rise = 1'b1;
            n_rise++;
        end
        if (!crank && prev_crank && mon_on && have_rise) begin
            if (exp_hi.size() == 0) check("crank_fall_unexpected", 0, 1);
            else check("crank_high_width", cyc - last_rise, exp_hi.pop_front());
        end
        if (cam && !prev_cam && cam_chk) begin
            cam_rise = cyc;
            if (exp_cam.size() == 0) check("cam_rise_unexpected", 0, 1);
            else begin
                check("cam_rise_slot", int'(tooth_idx), 5);
                check("cam_rise_rev_odd", int'(rev_odd), 1);
            end
        end
        if (!cam && prev_cam && cam_chk && exp_cam.size() != 0) begin
            check("cam_high_width", cyc - cam_rise, exp_cam.pop_front());
        end
        prev_crank = crank;
        prev_cam   = cam;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int p);
        period_in   = PERIOD_W'(p);
        period_load = 1'b1;
        step();
        period_load = 1'b0;
    endtask

    task automatic wait_idx(input int idx, input int budget);
        int n = 0;
        while (int'(tooth_idx) != idx && n < budget) begin
            step();
            n++;
        end
        check("wait_slot", int'(tooth_idx), idx);
    endtask

    task automatic wait_drained(input string tag, input int budget);
        int n = 0;
        while ((exp_iv.size() + exp_hi.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, exp_iv.size() + exp_hi.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int c1;
        int c2;
        int r0;
        rst = 1'b1; enable = 1'b0; ramp_mode = 1'b0; period_in = '0; period_load = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_tooth_idx", int'(tooth_idx), 0);
        check("rst_cur_period", int'(cur_period), 1000);
        check("rst_crank", int'(crank), 0);
        check("rst_cam", int'(cam), 0);
        check("rst_sync", int'(sync_pulse), 0);
        check("rst_rev_odd", int'(rev_odd), 0);

        // Default 36-1 at 1000: 35 teeth, 2000 across the gap, 500 high each.
        for (int i = 0; i < 34; i++) exp_iv.push_back(1000);
        exp_iv.push_back(2000);
        exp_iv.push_back(1000);
        for (int i = 0; i < 37; i++) exp_hi.push_back(500);
        mon_on = 1'b1;
        enable = 1'b1;
        wait_drained("default_rev_drained", 40000);
        mon_on = 1'b0;
        check("rev1_rev_odd", int'(rev_odd), 1);

        // Odd revolution: cam over slots 5-6.
        exp_cam.push_back(2000);
        wait_idx(7, 8000);
        repeat (600) step();
        check("cam_done", exp_cam.size(), 0);
        cam_chk = 1'b0;

        // Step mode: load 500 mid-slot.
        load(500);
        check("cur_hold_mid_slot", int'(cur_period), 1000);
        exp_iv.push_back(1000); exp_iv.push_back(500); exp_iv.push_back(500);
        repeat (3) exp_hi.push_back(250);
        mon_on = 1'b1;
        wait_drained("step_load_drained", 3000);
        mon_on = 1'b0;
        check("cur_after_step", int'(cur_period), 500);

        // Ramp 1000 -> 950.
        load(1000);
        wait_idx(11, 2000);
        repeat (10) step();
        ramp_mode = 1'b1;
        load(950);
        exp_iv.push_back(1000); exp_iv.push_back(990); exp_iv.push_back(980);
        exp_iv.push_back(970);  exp_iv.push_back(960); exp_iv.push_back(950);
        exp_iv.push_back(950);
        exp_hi.push_back(500); exp_hi.push_back(495); exp_hi.push_back(490);
        exp_hi.push_back(485); exp_hi.push_back(480); exp_hi.push_back(475);
        exp_hi.push_back(475); exp_hi.push_back(475);
        mon_on = 1'b1;
        wait_drained("ramp_drained", 9000);
        mon_on = 1'b0;
        ramp_mode = 1'b0;
        check("ramp_settled", int'(cur_period), 950);

        // Enable low 300 cycles at tick 200 of slot 19.
        wait_idx(19, 2000);
        repeat (200) step();
        enable = 1'b0;
        step();
        check("disable_crank_low", int'(crank), 0);
        bad = 0;
        repeat (299) begin
            step();
            if (crank || cam || sync_pulse || int'(tooth_idx) != 19) bad++;
        end
        check("disable_frozen", bad, 0);
        enable = 1'b1;
        n = 0;
        bad = 0;
        while (!(crank && int'(tooth_idx) == 20) && n < 2000) begin
            step();
            n++;
            if (sync_pulse) bad++;
        end
        check("resume_remaining_ticks", n, 751);
        check("resume_no_sync", bad, 0);

        // Period 100: one full revolution between sync pulses.
        load(100);
        n = 0;
        while (!sync_pulse && n < 20000) begin step(); n++; end
        check("sync1_seen", int'(sync_pulse), 1);
        check("sync1_rev_odd", int'(rev_odd), 0);
        c1 = cyc;
        r0 = n_rise;
        step();
        check("sync_one_cycle", int'(sync_pulse), 0);
        n = 0;
        while (!sync_pulse && n < 5000) begin step(); n++; end
        c2 = cyc;
        check("sync_interval", c2 - c1, 3600);
        check("sync2_rev_odd", int'(rev_odd), 1);
        check("teeth_per_rev", n_rise - r0, 35);
        check("gap_last_rise_to_sync", c2 - last_rise, 199);

        // Clamp of 0, then a load on the exact boundary cycle.
        load(0);
        wait_idx(1, 500);
        check("min_clamp", int'(cur_period), 4);
        repeat (3) step();
        load(20);
        check("boundary_load_idx", int'(tooth_idx), 2);
        check("boundary_load_period", int'(cur_period), 20);

        // Reset mid-revolution.
        repeat (7) step();
        rst = 1'b1;
        step();
        check("midrst_tooth_idx", int'(tooth_idx), 0);
        check("midrst_cur_period", int'(cur_period), 1000);
        check("midrst_crank", int'(crank), 0);
        check("midrst_cam", int'(cam), 0);
        check("midrst_sync", int'(sync_pulse), 0);
        check("midrst_rev_odd", int'(rev_odd), 0);
        rst = 1'b0;
        step();
        check("post_rst_crank", int'(crank), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
